// File: rtl/bictr_sweep_ctrl.sv
// bictr_sweep_ctrl: drives an up/down counter with a dynamic count-to compare so
// that it sweeps lo -> hi -> lo a programmed number of times, then pulses done.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start                     one-cycle request, honoured only when idle
//   abort                     return to idle on the next edge from any state
//   hold                      pause counting (gates ctr_cen only)
//   lo, hi, cycles            sweep bounds and sweep count, latched on accepted start
//   tercnt                    counter terminal-count flag (count == ctr_count_to)
//   ctr_load (active-low), ctr_cen, ctr_up_dn, ctr_data, ctr_count_to
//                             counter controls, combinational from state/latches/tercnt
//   busy                      high during LOAD/UP/DOWN
//   done                      one-cycle pulse at sweep completion
//   err                       one-cycle pulse after a rejected start
//   cycle_cnt                 completed sweeps in the current run
module bictr_sweep_ctrl #(
    parameter int unsigned width = 4,
    parameter int unsigned cw    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [width-1:0] lo,
    input  logic [width-1:0] hi,
    input  logic [cw-1:0]    cycles,
    input  logic             tercnt,
    output logic             ctr_load,
    output logic             ctr_cen,
    output logic             ctr_up_dn,
    output logic [width-1:0] ctr_data,
    output logic [width-1:0] ctr_count_to,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [cw-1:0]    cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [width-1:0] lo_q, lo_nxt;
    logic [width-1:0] hi_q, hi_nxt;
    logic [cw-1:0]    cycles_q, cycles_nxt;
    logic [cw-1:0]    cnt_q, cnt_nxt;
    logic [cw-1:0]    cnt_inc;
    logic             err_q, err_nxt;

    // State and latched-parameter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            cycles_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            lo_q     <= lo_nxt;
            hi_q     <= hi_nxt;
            cycles_q <= cycles_nxt;
            cnt_q    <= cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state and counter-control decode
    always_comb begin
        state_nxt    = state;
        lo_nxt       = lo_q;
        hi_nxt       = hi_q;
        cycles_nxt   = cycles_q;
        cnt_nxt      = cnt_q;
        cnt_inc      = cnt_q + cw'(1);
        err_nxt      = 1'b0;
        ctr_load     = 1'b1;
        ctr_cen      = 1'b0;
        ctr_up_dn    = 1'b1;
        ctr_data     = '0;
        ctr_count_to = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if ((lo > hi) || (cycles == '0)) begin
                        err_nxt = 1'b1;
                    end else begin
                        lo_nxt     = lo;
                        hi_nxt     = hi;
                        cycles_nxt = cycles;
                        cnt_nxt    = '0;
                        state_nxt  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                ctr_load     = 1'b0;
                ctr_data     = lo_q;
                ctr_count_to = hi_q;
                state_nxt    = S_UP;
            end
            S_UP: begin
                // Enable drops in the tercnt cycle so the count never passes hi
                busy         = 1'b1;
                ctr_count_to = hi_q;
                ctr_cen      = ~tercnt & ~hold;
                if (tercnt) begin
                    state_nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                busy         = 1'b1;
                ctr_up_dn    = 1'b0;
                ctr_count_to = lo_q;
                ctr_cen      = ~tercnt & ~hold;
                if (tercnt) begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = (cnt_inc == cycles_q) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every transition and leaves latched values untouched
        if (abort) begin
            state_nxt  = S_IDLE;
            lo_nxt     = lo_q;
            hi_nxt     = hi_q;
            cycles_nxt = cycles_q;
            cnt_nxt    = cnt_q;
            err_nxt    = 1'b0;
        end
    end

    assign err       = err_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_bictr_sweep_ctrl.sv
// tb_bictr_sweep_ctrl: sweep controller driving a behavioural up/down counter,
// checked every cycle against a sweep-level reference model, plus literal
// expectations for the directed scenarios.
module tb_bictr_sweep_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;
    localparam int MODN = 16;

    // Reference phases of a run
    localparam int REST   = 0;
    localparam int PRIME  = 1;
    localparam int RISE   = 2;
    localparam int FALL   = 3;
    localparam int FINISH = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          hold;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [CW-1:0] cycles;
    logic          tercnt;
    logic          ctr_load;
    logic          ctr_cen;
    logic          ctr_up_dn;
    logic [W-1:0]  ctr_data;
    logic [W-1:0]  ctr_count_to;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cycle_cnt;

    int checks;
    int errors;
    logic chk_en;

    bictr_sweep_ctrl #(.width(W), .cw(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .hold         (hold),
        .lo           (lo),
        .hi           (hi),
        .cycles       (cycles),
        .tercnt       (tercnt),
        .ctr_load     (ctr_load),
        .ctr_cen      (ctr_cen),
        .ctr_up_dn    (ctr_up_dn),
        .ctr_data     (ctr_data),
        .ctr_count_to (ctr_count_to),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cycle_cnt    (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Downstream counter (plant) and the sweep-level reference model
    int cnt;
    int m_phase;
    int m_lo;
    int m_hi;
    int m_cyc;
    int m_sweeps;
    logic m_err;

    assign tercnt = (cnt == int'(ctr_count_to));

    always @(posedge clk) begin
        if (rst) begin
            cnt      <= 0;
            m_phase  <= REST;
            m_lo     <= 0;
            m_hi     <= 0;
            m_cyc    <= 0;
            m_sweeps <= 0;
            m_err    <= 1'b0;
        end else begin
            if (!ctr_load)
                cnt <= int'(ctr_data);
            else if (ctr_cen)
                cnt <= ctr_up_dn ? (cnt + 1) % MODN : (cnt + MODN - 1) % MODN;
            m_err <= 1'b0;
            if (abort) begin
                m_phase <= REST;
            end else begin
                case (m_phase)
                    REST:
                        if (start) begin
                            if (int'(lo) > int'(hi) || int'(cycles) == 0) begin
                                m_err <= 1'b1;
                            end else begin
                                m_lo     <= int'(lo);
                                m_hi     <= int'(hi);
                                m_cyc    <= int'(cycles);
                                m_sweeps <= 0;
                                m_phase  <= PRIME;
                            end
                        end
                    PRIME: m_phase <= RISE;
                    RISE:  if (cnt == m_hi) m_phase <= FALL;
                    FALL:
                        if (cnt == m_lo) begin
                            m_sweeps <= m_sweeps + 1;
                            m_phase  <= (m_sweeps + 1 == m_cyc) ? FINISH : RISE;
                        end
                    default: m_phase <= REST;
                endcase
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    logic counting;
    int   target;
    always @(negedge clk) begin
        if (chk_en) begin
            counting = (m_phase == RISE) || (m_phase == FALL);
            target   = (m_phase == RISE) ? m_hi : m_lo;
            chk("busy", 32'(busy), (m_phase == PRIME || counting) ? 1 : 0);
            chk("done", 32'(done), (m_phase == FINISH) ? 1 : 0);
            chk("err", 32'(err), 32'(m_err));
            chk("cycle_cnt", 32'(cycle_cnt), m_sweeps);
            chk("ctr_load", 32'(ctr_load), (m_phase == PRIME) ? 0 : 1);
            chk("ctr_data", 32'(ctr_data), (m_phase == PRIME) ? m_lo : 0);
            chk("ctr_up_dn", 32'(ctr_up_dn), (m_phase == FALL) ? 0 : 1);
            chk("ctr_count_to", 32'(ctr_count_to),
                (m_phase == PRIME) ? m_hi : (counting ? target : 0));
            chk("ctr_cen", 32'(ctr_cen), (counting && cnt != target && !hold) ? 1 : 0);
            if (counting)
                chk("count_in_range", (cnt >= m_lo && cnt <= m_hi) ? 1 : 0, 1);
        end
    end

    // Per-cycle traces of a directed run, indexed by cycle after start
    logic busy_tr [64];
    logic done_tr [64];
    logic cen_tr  [64];
    logic load_tr [64];
    logic err_tr  [64];
    int   cnt_tr  [64];
    int   data_tr [64];
    int   cto_tr  [64];
    int   ccnt_tr [64];

    // Start in cycle 0; hold over [hf,ht], abort in cycle ab, rst in cycle rs
    task automatic run_dir(input int l, input int h, input int c, input int hf, input int ht,
                           input int ab, input int rs, input int budget, output int done_cyc);
        lo     = W'(l);
        hi     = W'(h);
        cycles = CW'(c);
        start  = 1'b1;
        done_cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            hold  = (k >= hf && k <= ht);
            abort = (k == ab);
            rst   = (k == rs);
            lo    = W'($urandom_range(0, 15));
            hi    = W'($urandom_range(0, 15));
            cycles = CW'($urandom_range(0, 5));
            @(negedge clk);
            busy_tr[k] = busy;
            done_tr[k] = done;
            cen_tr[k]  = ctr_cen;
            load_tr[k] = ctr_load;
            err_tr[k]  = err;
            cnt_tr[k]  = cnt;
            data_tr[k] = int'(ctr_data);
            cto_tr[k]  = int'(ctr_count_to);
            ccnt_tr[k] = int'(cycle_cnt);
            if (done && done_cyc < 0) done_cyc = k;
        end
        @(posedge clk);
        #1;
        hold  = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    int dc;
    int n;
    int exp_seq [10];

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        hold   = 1'b0;
        lo     = '0;
        hi     = '0;
        cycles = '0;
        exp_seq = '{3, 4, 5, 6, 6, 5, 4, 3, 3, 4};

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_load", 32'(ctr_load), 1);
        chk("reset_cen", 32'(ctr_cen), 0);
        chk("reset_up_dn", 32'(ctr_up_dn), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cycle_cnt", 32'(cycle_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic two-sweep triangle
        run_dir(3, 6, 2, -1, -1, -1, -1, 20, dc);
        chk("s1_done_cycle", dc, 18);
        chk("s1_load_c1", 32'(load_tr[1]), 0);
        chk("s1_data_c1", data_tr[1], 3);
        for (int k = 0; k < 10; k++)
            chk("s1_count_seq", cnt_tr[k + 2], exp_seq[k]);
        chk("s1_busy_c17", 32'(busy_tr[17]), 1);
        chk("s1_busy_c18", 32'(busy_tr[18]), 0);
        chk("s1_cycle_cnt", ccnt_tr[18], 2);
        n = 0;
        for (int k = 1; k <= 20; k++) if (done_tr[k]) n++;
        chk("s1_done_pulses", n, 1);

        // Full-range turnaround
        run_dir(0, 15, 1, -1, -1, -1, -1, 36, dc);
        chk("s2_done_cycle", dc, 34);
        chk("s2_top_c17", cnt_tr[17], 15);
        chk("s2_cen_top_c17", 32'(cen_tr[17]), 0);
        chk("s2_no_wrap_c18", cnt_tr[18], 15);
        chk("s2_bottom_c33", cnt_tr[33], 0);

        // Degenerate lo == hi
        run_dir(5, 5, 3, -1, -1, -1, -1, 10, dc);
        chk("s3_done_cycle", dc, 8);
        n = 0;
        for (int k = 2; k <= 8; k++) if (cen_tr[k] || cnt_tr[k] != 5) n++;
        chk("s3_static_count", n, 0);

        // Rejected starts
        run_dir(9, 4, 2, -1, -1, -1, -1, 6, dc);
        chk("s4a_err_c1", 32'(err_tr[1]), 1);
        chk("s4a_err_c2", 32'(err_tr[2]), 0);
        n = 0;
        for (int k = 1; k <= 6; k++) if (busy_tr[k] || !load_tr[k]) n++;
        chk("s4a_quiet", n, 0);
        run_dir(1, 2, 0, -1, -1, -1, -1, 6, dc);
        chk("s4b_err_c1", 32'(err_tr[1]), 1);
        chk("s4b_err_c2", 32'(err_tr[2]), 0);
        n = 0;
        for (int k = 1; k <= 6; k++) if (busy_tr[k] || !load_tr[k]) n++;
        chk("s4b_quiet", n, 0);

        // Hold over cycles 3..5
        run_dir(3, 6, 2, 3, 5, -1, -1, 23, dc);
        chk("s5_done_cycle", dc, 21);
        n = 0;
        for (int k = 3; k <= 6; k++) if (cnt_tr[k] != 4) n++;
        chk("s5_frozen", n, 0);

        // Abort in cycle 7
        run_dir(3, 6, 2, -1, -1, 7, -1, 22, dc);
        chk("s6_abort_no_done", dc, -1);
        chk("s6_busy_c7", 32'(busy_tr[7]), 1);
        chk("s6_busy_c8", 32'(busy_tr[8]), 0);
        chk("s6_cen_c8", 32'(cen_tr[8]), 0);

        // Reset mid-run, after one completed sweep
        run_dir(3, 6, 2, -1, -1, -1, 14, 16, dc);
        chk("s6_rst_ccnt_c13", ccnt_tr[13], 1);
        chk("s6_rst_load", 32'(load_tr[15]), 1);
        chk("s6_rst_cen", 32'(cen_tr[15]), 0);
        chk("s6_rst_busy", 32'(busy_tr[15]), 0);
        chk("s6_rst_cto", cto_tr[15], 0);
        chk("s6_rst_ccnt", ccnt_tr[15], 0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst    = ($urandom_range(0, 999) == 0);
            abort  = ($urandom_range(0, 63) == 0);
            start  = !abort && ($urandom_range(0, 5) == 0);
            hold   = ($urandom_range(0, 4) == 0);
            lo     = W'($urandom_range(0, 15));
            hi     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15))
                                                 : W'($urandom_range(15, int'(lo)));
            cycles = CW'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b1;
        hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
